uart_tx_arbiter: RTL

Shares one `uart_tx` transmitter among `NUM_REQ` byte-stream requesters, such as an echo FIFO, a status reporter and a debug dump. It sits between the requesters' valid/ready byte interfaces and the transmitter's `write_i`/`data_i`/`busy_o` port. Grants are round-robin and locked per packet, so packets never interleave on the wire. A cork input pauses transmission at byte boundaries, and a byte limit stops a runaway requester from holding the line indefinitely.

---
 rtl/uart_tx_arbiter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx among NUM_REQ byte-stream requesters.
// Grants are locked per packet; cork pauses at byte boundaries; MAX_PACKET caps a grant.
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int MAX_PACKET = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]   req_last_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  input  logic                 cork_i,
  output logic                 tx_write_o,
  output logic [7:0]           tx_data_o,
  input  logic                 tx_busy_i,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 overrun_o
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (MAX_PACKET > 0) ? $clog2(MAX_PACKET + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(MAX_PACKET);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    WRITE,
    GAP
  } state_t;

  state_t       state, state_d;
  logic [IW-1:0] owner, owner_d;
  logic [IW-1:0] rr_last, rr_last_d;
  logic [NUM_REQ-1:0] grant_d;
  logic [CW-1:0] count, count_d;
  logic [7:0]    data_d;
  logic          pkt_last, pkt_last_d;

  logic [IW-1:0] pick;
  logic [IW-1:0] cand;
  logic          found;
  logic          can_accept;
  logic          limit_hit;

  // Search starts just after the previous owner so it gets lowest priority next.
  always_comb begin
    pick  = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((32'(rr_last) + k) % NUM_REQ);
      if (!found && req_valid_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  assign can_accept = !tx_busy_i && !cork_i;
  assign limit_hit  = (MAX_PACKET != 0) && (count == LIMIT);

  always_comb begin
    state_d     = state;
    owner_d     = owner;
    rr_last_d   = rr_last;
    grant_d     = grant_o;
    count_d     = count;
    data_d      = tx_data_o;
    pkt_last_d  = pkt_last;
    req_ready_o = '0;
    tx_write_o  = 1'b0;
    overrun_o   = 1'b0;

    case (state)
      IDLE: begin
        if (found && !cork_i) begin
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          count_d       = '0;
          state_d       = SEND;
        end
      end

      SEND: begin
        req_ready_o[owner] = can_accept;
        if (can_accept && req_valid_i[owner]) begin
          data_d     = req_data_i[8*owner +: 8];
          pkt_last_d = req_last_i[owner];
          count_d    = (count == '1) ? count : count + 1'b1;
          state_d    = WRITE;
        end
      end

      WRITE: begin
        tx_write_o = 1'b1;
        state_d    = GAP;
      end

      GAP: begin
        if (pkt_last || limit_hit) begin
          rr_last_d = owner;
          grant_d   = '0;
          overrun_o = !pkt_last;
          state_d   = IDLE;
        end else begin
          state_d = SEND;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      owner     <= '0;
      rr_last   <= IW'(NUM_REQ - 1);
      grant_o   <= '0;
      count     <= '0;
      tx_data_o <= '0;
      pkt_last  <= 1'b0;
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      rr_last   <= rr_last_d;
      grant_o   <= grant_d;
      count     <= count_d;
      tx_data_o <= data_d;
      pkt_last  <= pkt_last_d;
    end
  end

endmodule
